// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 inverse cipher, one round per clock.
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   start      - decrypt request, sampled only while idle
//   key        - AES-128 cipher key (same key as used for encryption)
//   ciphertext - block to decrypt
//   plaintext  - registered result, updated only in the final round
//   busy       - high while an operation is in progress
//   done       - high while plaintext holds a valid result
// Byte 0 sits in bits [127:120]; bytes are column-major (byte 4*c+r is row r, column c).
// The cipher key is first expanded forward to round key 10, then rolled backwards one
// round key per round so that no key schedule storage is needed.
// aes_sbox (the S-box submodule) shares this file.

module aes_sbox #(
   parameter bit Inverse = 1'b0
) (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] t;
      t = gf_mul(gf_mul(x, x), x);   // x^3
      t = gf_mul(gf_mul(t, t), x);   // x^7
      t = gf_mul(gf_mul(t, t), x);   // x^15
      t = gf_mul(gf_mul(t, t), x);   // x^31
      t = gf_mul(gf_mul(t, t), x);   // x^63
      t = gf_mul(gf_mul(t, t), x);   // x^127
      return gf_mul(t, t);           // x^254
   endfunction

   if (Inverse) begin : g_inv
      logic [7:0] pre;
      // Inverse affine transform precedes the field inversion.
      assign pre   = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]}
                     ^ 8'h05;
      assign out_o = gf_inv(pre);
   end else begin : g_fwd
      logic [7:0] v;
      assign v     = gf_inv(in_i);
      assign out_o = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                     ^ {v[3:0], v[7:4]} ^ 8'h63;
   end

endmodule

module aes_inv_cipher (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ciphertext,
   output logic [127:0] plaintext,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {StIdle, StKexp, StInit, StRound, StFinal} state_e;

   state_e       st_q, st_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] ct_q, ct_d;
   logic [127:0] pt_q, pt_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [3:0][7:0] m9, mb, md, me;
      logic [7:0]      a, a2, a4, a8;
      logic [31:0]     o;
      for (int i = 0; i < 4; i++) begin
         a     = col[31-8*i -: 8];
         a2    = xt(a);
         a4    = xt(a2);
         a8    = xt(a4);
         m9[i] = a8 ^ a;
         mb[i] = a8 ^ a2 ^ a;
         md[i] = a8 ^ a4 ^ a;
         me[i] = a8 ^ a4 ^ a2;
      end
      for (int i = 0; i < 4; i++) begin
         o[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   // Key schedule: one forward step (KEXP) or one backward step (INIT/ROUND).
   logic [31:0]  w0, w1, w2, w3, p1, p2, p3, sub_in, rot, sub_word, f0, f1, f2;
   logic [127:0] rk_fwd, rk_inv;

   assign {w0, w1, w2, w3} = rk_q;
   assign p3     = w3 ^ w2;
   assign p2     = w2 ^ w1;
   assign p1     = w1 ^ w0;
   // Forward uses the old w3; backward needs the recovered w3 (= p3).
   assign sub_in = (st_q == StKexp) ? w3 : p3;
   assign rot    = {sub_in[23:0], sub_in[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_ksbox
      aes_sbox #(.Inverse(1'b0)) u_sbox (
         .in_i  (rot[31-8*i -: 8]),
         .out_o (sub_word[31-8*i -: 8])
      );
   end

   assign f0     = w0 ^ sub_word ^ {rcon(cnt_q), 24'h0};
   assign f1     = w1 ^ f0;
   assign f2     = w2 ^ f1;
   assign rk_fwd = {f0, f1, f2, w3 ^ f2};
   assign rk_inv = {w0 ^ sub_word ^ {rcon(cnt_q), 24'h0}, p1, p2, p3};

   // Round datapath: InvShiftRows then InvSubBytes, shared by ROUND and FINAL.
   logic [127:0] shifted, isb, mixed;

   assign shifted = inv_shift_rows(blk_q);

   for (genvar i = 0; i < 16; i++) begin : g_isbox
      aes_sbox #(.Inverse(1'b1)) u_sbox (
         .in_i  (shifted[127-8*i -: 8]),
         .out_o (isb[127-8*i -: 8])
      );
   end

   assign mixed = inv_mix_columns(isb ^ rk_q);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= StIdle;
      else        st_q <= st_d;
   end

   // Next-state logic.
   always_comb begin
      st_d = st_q;
      case (st_q)
         StIdle:  if (start) st_d = StKexp;
         StKexp:  if (cnt_q == 4'd10) st_d = StInit;
         StInit:  st_d = StRound;
         StRound: if (cnt_q == 4'd1) st_d = StFinal;
         StFinal: st_d = StIdle;
         default: st_d = StIdle;
      endcase
   end

   // Datapath and output next-state logic.
   always_comb begin
      cnt_d  = cnt_q;
      rk_d   = rk_q;
      blk_d  = blk_q;
      ct_d   = ct_q;
      pt_d   = pt_q;
      busy_d = busy_q;
      done_d = done_q;
      case (st_q)
         StIdle: begin
            if (start) begin
               rk_d   = key;
               ct_d   = ciphertext;
               cnt_d  = 4'd1;
               busy_d = 1'b1;
               done_d = 1'b0;
            end
         end
         StKexp: begin
            rk_d = rk_fwd;
            // Counter stays at 10 so INIT sees the rcon for rk10 -> rk9.
            if (cnt_q != 4'd10) cnt_d = cnt_q + 4'd1;
         end
         StInit: begin
            blk_d = ct_q ^ rk_q;
            rk_d  = rk_inv;
            cnt_d = cnt_q - 4'd1;
         end
         StRound: begin
            blk_d = mixed;
            rk_d  = rk_inv;
            cnt_d = cnt_q - 4'd1;
         end
         StFinal: begin
            pt_d   = isb ^ rk_q;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 4'd0;
         rk_q   <= '0;
         blk_q  <= '0;
         ct_q   <= '0;
         pt_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rk_q   <= rk_d;
         blk_q  <= blk_d;
         ct_q   <= ct_d;
         pt_q   <= pt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign plaintext = pt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to decrypt; sampled only when idle.
REQ-004 SHALL have port key, input, 128 bits: AES-128 cipher key (same key used for encryption).
REQ-005 SHALL have port ciphertext, input, 128 bits: block to decrypt.
REQ-006 SHALL have port plaintext, output, 128 bits: registered result.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: high while plaintext holds a valid result.
REQ-009 SHALL map byte 0 to bits [127:120], with bytes column-major per FIPS-197, on all 128-bit ports.

Function
REQ-010 SHALL implement the FIPS-197 AES-128 inverse cipher, one round per clock, iteratively.
REQ-011 SHALL use FSM states IDLE, KEXP, INIT, ROUND and FINAL.
REQ-012 IDLE: start=1 at an edge latches key and ciphertext, clears done, sets busy, loads round counter=1 and enters KEXP.
REQ-013 KEXP: each edge applies one forward key-expansion step (RotWord, SubWord, Rcon 01,02,04,...,36) to the round-key register.
REQ-014 KEXP: after 10 steps the round-key register SHALL hold round key 10, then the FSM enters INIT.
REQ-015 INIT: state <= ciphertext XOR rk10; rk <= inverse-expanded rk9; then the FSM enters ROUND.
REQ-016 ROUND, r = 9 down to 1, one edge each: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_r); rk <= rk_(r-1).
REQ-017 FINAL: plaintext <= InvSubBytes(InvShiftRows(state)) XOR rk0; done <= 1; busy <= 0; return to IDLE.
REQ-018 SHALL compute the inverse key step, with k = current words w0..w3, as: p3 = w3^w2; p2 = w2^w1; p1 = w1^w0; p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon.
REQ-019 SHALL apply Rcon in the inverse step in the order 36,1b,80,40,20,10,08,04,02,01 (rk9 down to rk0).
REQ-020 SHALL have a latency of exactly 21 edges from the edge that samples start to the edge after which done=1 (10 KEXP + 1 INIT + 9 ROUND + 1 FINAL).
REQ-021 SHALL ignore start while busy=1, leaving the latched inputs unchanged.
REQ-022 SHALL hold done=1 and plaintext stable in IDLE until the next accepted start.
REQ-023 SHALL accept start on the same edge if start is asserted while done=1, clearing done on that edge.
REQ-024 SHALL keep plaintext unchanged during an operation and update it only in FINAL.
REQ-025 SHALL instantiate forward and inverse S-box lookups as combinational submodules; the 256-entry tables are excluded from the RTL size budget.

Reset
REQ-026 SHALL, when reset=0, asynchronously force IDLE, plaintext=0, done=0, busy=0, and clear the state, round-key and counter registers.
REQ-027 SHALL abort a reset asserted mid-operation with no partial result; start is honoured from the first edge after release.

Verification
REQ-028 SHALL verify: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32, 1-cycle start -> plaintext=3243f6a8885a308d313198a2e0370734, done rises exactly 21 edges later, busy high throughout.
REQ-029 SHALL verify: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff.
REQ-030 SHALL verify round-key tracking for key 2b7e...4f3c: after KEXP, the internal rk = d014f9a8c9ee2589e13f0cc8b6630ca6; in FINAL, rk = 2b7e151628aed2a6abf7158809cf4f3c.
REQ-031 SHALL verify: second start pulse and changed key/ct at edge 5 of an operation -> ignored; result equals the first vector's plaintext.
REQ-032 SHALL verify: reset=0 at edge 12 -> done=0, busy=0, plaintext=0 immediately; a new start after release completes correctly in 21 edges.
REQ-033 SHALL verify: start held high continuously -> back-to-back operations, done high for exactly one cycle between them, each result correct.
